// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data-length codes and parity helper.
// Used by both the transmit path and the receive path so their frame formats always agree.
package uart_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 16;
    localparam int unsigned DIV_WIDTH       = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        LEN_5 = 2'b00,
        LEN_6 = 2'b01,
        LEN_7 = 2'b10,
        LEN_8 = 2'b11
    } bit_len_t;

    typedef struct packed {
        logic [7:0] data;
        bit_len_t   len;
        logic       parity_en;
        logic       odd;
    } frame_cfg_t;

    function automatic logic [3:0] len_of(input bit_len_t code);
        logic [3:0] n;
        case (code)
            LEN_5:   n = 4'd5;
            LEN_6:   n = 4'd6;
            LEN_7:   n = 4'd7;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Only the low n data bits take part; odd=1 makes the total count of ones odd.
    function automatic logic parity_of(input logic [7:0] data, input logic [3:0] n, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled and pulses tick on the terminal count.
module uart_baud_tick import uart_pkg::*; #(
    parameter int unsigned DIV = CLK_DIV_DEFAULT
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] TERMINAL = DIV_WIDTH'(DIV - 1);

    logic [DIV_WIDTH-1:0] count;

    assign tick = enable && (count == TERMINAL);

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_write.sv
// UART transmitter: one byte per accepted request, framed as start, 5..8 data bits
// LSB-first, optional parity and STOP_BITS stop bits, each bit lasting CLK_DIV clocks.
module uart_write import uart_pkg::*; #(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic [7:0] Tx_Data_i,
    input  logic       Tx_Start_i,
    input  logic [1:0] Tx_BitLength_i,
    input  logic       Tx_ParityEN_i,
    input  logic       Tx_OddParity_i,
    input  logic       Tx_Enable_i,
    output logic       TxD_o,
    output logic       Tx_Ready_o,
    output logic       Tx_Done_o,
    output logic       Tx_ShiftClock_o
);

    uart_state_t state;
    uart_state_t state_next;
    frame_cfg_t  shadow;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_next;
    logic        stop_idx;
    logic        stop_idx_next;
    logic        accept;
    logic        busy;
    logic        bit_tick;
    logic        last_data;
    logic        last_stop;
    logic [3:0]  data_len;

    assign busy      = (state != ST_IDLE);
    assign accept    = (state == ST_IDLE) && Tx_Start_i && Tx_Enable_i;
    assign data_len  = len_of(shadow.len);
    assign last_data = ({1'b0, bit_idx} == (data_len - 4'd1));
    assign last_stop = (STOP_BITS < 2) || stop_idx;

    // Held cleared while idle so every frame starts with a full-length start bit.
    uart_baud_tick #(
        .DIV(CLK_DIV)
    ) u_baud_tick (
        .m_clock(m_clock),
        .p_reset(p_reset),
        .clear  (!busy),
        .enable (busy),
        .tick   (bit_tick)
    );

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state    <= ST_IDLE;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
            shadow   <= '{data: 8'h00, len: LEN_8, parity_en: 1'b0, odd: 1'b0};
        end else begin
            state    <= state_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            if (accept) begin
                shadow <= '{data:      Tx_Data_i,
                            len:       bit_len_t'(Tx_BitLength_i),
                            parity_en: Tx_ParityEN_i,
                            odd:       Tx_OddParity_i};
            end
        end
    end

    always_comb begin
        state_next      = state;
        bit_idx_next    = bit_idx;
        stop_idx_next   = stop_idx;
        TxD_o           = 1'b1;
        Tx_Ready_o      = 1'b0;
        Tx_Done_o       = 1'b0;
        Tx_ShiftClock_o = busy && bit_tick;

        case (state)
            ST_IDLE: begin
                Tx_Ready_o    = 1'b1;
                bit_idx_next  = 3'd0;
                stop_idx_next = 1'b0;
                if (accept) begin
                    state_next = ST_START;
                end
            end

            ST_START: begin
                TxD_o = 1'b0;
                if (bit_tick) begin
                    state_next = ST_DATA;
                end
            end

            ST_DATA: begin
                TxD_o = shadow.data[bit_idx];
                if (bit_tick) begin
                    if (last_data) begin
                        bit_idx_next = 3'd0;
                        state_next   = shadow.parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end

            ST_PARITY: begin
                TxD_o = parity_of(shadow.data, data_len, shadow.odd);
                if (bit_tick) begin
                    state_next = ST_STOP;
                end
            end

            ST_STOP: begin
                TxD_o = 1'b1;
                if (bit_tick) begin
                    if (last_stop) begin
                        state_next = ST_IDLE;
                        Tx_Done_o  = 1'b1;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
